// File: rtl/usr_irq_responder.sv
// User-interrupt responder: captures partition requests, round-robin arbitrates them onto the
// MSI request port with fail/retry, and acks a line once granted. Optional counters: USR_IRQ_STATS_EN.
module usr_irq_responder #(
  parameter int NUM_IRQ   = 4,
  parameter int RETRY_GAP = 16
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  input  logic [NUM_IRQ-1:0] usr_irq_req,
  output logic [NUM_IRQ-1:0] usr_irq_ack,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               irq_en,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               msi_req,
  output logic [4:0]         msi_vec,
  input  logic               msi_grant,
  input  logic               msi_fail
`ifdef USR_IRQ_STATS_EN
  ,
  output logic [31:0]        irq_sent_cnt,
  output logic [31:0]        irq_fail_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BACKOFF = 2'd2
  } state_e;

  localparam logic [7:0] GAP_LAST = 8'(RETRY_GAP);
  localparam logic [4:0] VEC_LAST = 5'(NUM_IRQ - 1);

  state_e             state_r, state_s;
  logic [NUM_IRQ-1:0] req_r;
  logic [NUM_IRQ-1:0] pending_r, pending_s;
  logic [NUM_IRQ-1:0] wait_low_r, wait_low_s;
  logic [NUM_IRQ-1:0] ack_r, ack_s;
  logic [NUM_IRQ-1:0] elig_s, ge_ptr_s, hi_s, vec_oh_s;
  logic [4:0]         rr_ptr_r, rr_ptr_s;
  logic [4:0]         vec_r, vec_s, sel_s;
  logic [7:0]         gap_cnt_r, gap_cnt_s;
  logic               msi_req_r, msi_req_s;
  logic               any_elig_s, req_vec_s, grant_s, abort_s, inflight_s;

  // Lowest set bit index of a request vector.
  function automatic logic [4:0] first_set(input logic [NUM_IRQ-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int j = NUM_IRQ - 1; j >= 0; j--) begin
      idx = v[j] ? 5'(j) : idx;
    end
    return idx;
  endfunction

  // Eligibility and round-robin selection from the registered line states.
  always_comb begin
    vec_oh_s = {NUM_IRQ{1'b0}};
    ge_ptr_s = {NUM_IRQ{1'b0}};
    for (int j = 0; j < NUM_IRQ; j++) begin
      vec_oh_s[j] = (vec_r == 5'(j));
      ge_ptr_s[j] = (5'(j) >= rr_ptr_r);
    end
    // A line whose request already dropped is withdrawing, so it is never picked.
    elig_s     = pending_r & req_r & ~irq_mask;
    hi_s       = elig_s & ge_ptr_s;
    any_elig_s = |elig_s;
    sel_s      = (|hi_s) ? first_set(hi_s) : first_set(elig_s);
    req_vec_s  = |(req_r & vec_oh_s);
    inflight_s = (state_r != ST_IDLE);
  end

  // Global handshake FSM: next state, vector latch, retry gap and ack pulse.
  always_comb begin
    state_s   = state_r;
    vec_s     = vec_r;
    rr_ptr_s  = rr_ptr_r;
    gap_cnt_s = gap_cnt_r;
    ack_s     = {NUM_IRQ{1'b0}};
    grant_s   = 1'b0;
    abort_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The ack cycle is dead time so a new request never starts before g+2.
        if (irq_en && any_elig_s && !(|ack_r)) begin
          state_s = ST_ISSUE;
          vec_s   = sel_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (msi_grant) begin
          grant_s  = 1'b1;
          ack_s    = vec_oh_s;
          rr_ptr_s = (vec_r == VEC_LAST) ? 5'd0 : vec_r + 5'd1;
          state_s  = ST_IDLE;
        end else if (msi_fail) begin
          gap_cnt_s = 8'd0;
          state_s   = ST_BACKOFF;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_BACKOFF: begin
        if (!req_vec_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_ISSUE;
        end else begin
          gap_cnt_s = gap_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    msi_req_s = (state_s == ST_ISSUE);
  end

  // Per-line ARMABLE / PENDING / WAIT_LOW transitions (both flags clear = ARMABLE).
  always_comb begin
    pending_s  = pending_r;
    wait_low_s = wait_low_r;
    for (int j = 0; j < NUM_IRQ; j++) begin
      if (grant_s && vec_oh_s[j]) begin
        pending_s[j]  = 1'b0;
        wait_low_s[j] = 1'b1;
      end else if (abort_s && vec_oh_s[j]) begin
        pending_s[j]  = 1'b0;
        wait_low_s[j] = 1'b0;
      end else if (pending_r[j]) begin
        pending_s[j] = req_r[j] || (inflight_s && vec_oh_s[j]);
      end else if (wait_low_r[j]) begin
        wait_low_s[j] = req_r[j];
      end else begin
        pending_s[j] = req_r[j];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_r    <= ST_IDLE;
      req_r      <= {NUM_IRQ{1'b0}};
      pending_r  <= {NUM_IRQ{1'b0}};
      wait_low_r <= {NUM_IRQ{1'b0}};
      ack_r      <= {NUM_IRQ{1'b0}};
      rr_ptr_r   <= 5'd0;
      vec_r      <= 5'd0;
      gap_cnt_r  <= 8'd0;
      msi_req_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      req_r      <= usr_irq_req;
      pending_r  <= pending_s;
      wait_low_r <= wait_low_s;
      ack_r      <= ack_s;
      rr_ptr_r   <= rr_ptr_s;
      vec_r      <= vec_s;
      gap_cnt_r  <= gap_cnt_s;
      msi_req_r  <= msi_req_s;
    end
  end

  assign usr_irq_ack = ack_r;
  assign irq_pending = pending_r;
  assign msi_req     = msi_req_r;
  assign msi_vec     = vec_r;

`ifdef USR_IRQ_STATS_EN
  logic [31:0] sent_cnt_r, fail_cnt_r;

  // Accepted grant and fail event counters, free-running with natural wrap.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sent_cnt_r <= 32'd0;
      fail_cnt_r <= 32'd0;
    end else begin
      if (grant_s) begin
        sent_cnt_r <= sent_cnt_r + 32'd1;
      end
      if ((state_r == ST_ISSUE) && msi_fail && !msi_grant) begin
        fail_cnt_r <= fail_cnt_r + 32'd1;
      end
    end
  end

  assign irq_sent_cnt = sent_cnt_r;
  assign irq_fail_cnt = fail_cnt_r;
`endif

endmodule

// File: tb/tb_usr_irq_responder.sv
// Directed self-checking bench for usr_irq_responder (NUM_IRQ=4, RETRY_GAP=16).
module tb_usr_irq_responder;
  localparam int NUM_IRQ   = 4;
  localparam int RETRY_GAP = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] usr_irq_req = 4'd0;
  logic [3:0] usr_irq_ack;
  logic [3:0] irq_mask = 4'd0;
  logic       irq_en = 1'b1;
  logic [3:0] irq_pending;
  logic       msi_req;
  logic [4:0] msi_vec;
  logic       msi_grant = 1'b0;
  logic       msi_fail = 1'b0;
`ifdef USR_IRQ_STATS_EN
  logic [31:0] irq_sent_cnt, irq_fail_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int req_rises = 0;
  int ack_pulses = 0;
  logic req_prev = 1'b0;
  int base_r, base_a;

  usr_irq_responder #(.NUM_IRQ(NUM_IRQ), .RETRY_GAP(RETRY_GAP)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .usr_irq_req  (usr_irq_req),
    .usr_irq_ack  (usr_irq_ack),
    .irq_mask     (irq_mask),
    .irq_en       (irq_en),
    .irq_pending  (irq_pending),
    .msi_req      (msi_req),
    .msi_vec      (msi_vec),
    .msi_grant    (msi_grant),
    .msi_fail     (msi_fail)
`ifdef USR_IRQ_STATS_EN
    ,
    .irq_sent_cnt (irq_sent_cnt),
    .irq_fail_cnt (irq_fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Count msi_req rising edges and ack pulses seen on the falling edge.
  always @(negedge clk) begin
    req_prev <= msi_req;
    if (msi_req && !req_prev) req_rises <= req_rises + 1;
    ack_pulses <= ack_pulses + $countones(usr_irq_ack);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!msi_req && n < 40) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(msi_req), 32'd1);
  endtask

  task automatic do_grant(input string tag, input logic [3:0] exp_ack);
    msi_grant = 1'b1;
    tick(1);
    msi_grant = 1'b0;
    check_eq({tag, " ack"}, 32'(usr_irq_ack), 32'(exp_ack));
    check_eq({tag, " req drop"}, 32'(msi_req), 32'd0);
    tick(1);
    check_eq({tag, " ack single"}, 32'(usr_irq_ack), 32'd0);
    check_eq({tag, " gap"}, 32'(msi_req), 32'd0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    usr_irq_req = 4'd0;
    irq_mask    = 4'd0;
    irq_en      = 1'b1;
    msi_grant   = 1'b0;
    msi_fail    = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    check_eq("reset ack", 32'(usr_irq_ack), 32'd0);
    check_eq("reset pending", 32'(irq_pending), 32'd0);
    check_eq("reset msi_req", 32'(msi_req), 32'd0);
    check_eq("reset msi_vec", 32'(msi_vec), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single request: latency, one ack, no re-fire while held, re-fire after drop.
    usr_irq_req = 4'b0010;
    tick(1);
    check_eq("single pend k", 32'(irq_pending), 32'd0);
    tick(1);
    check_eq("single pend k+1", 32'(irq_pending), 32'h2);
    check_eq("single req k+1", 32'(msi_req), 32'd0);
    tick(1);
    check_eq("single req k+2", 32'(msi_req), 32'd1);
    check_eq("single vec", 32'(msi_vec), 32'd1);
    tick(2);
    check_eq("single req held", 32'(msi_req), 32'd1);
    do_grant("single", 4'b0010);
    base_r = req_rises;
    tick(10);
    check_eq("held no refire", 32'(req_rises), 32'(base_r));
    check_eq("held pending", 32'(irq_pending), 32'd0);
    usr_irq_req = 4'd0;
    tick(3);
    usr_irq_req = 4'b0010;
    wait_req("second req");
    check_eq("second vec", 32'(msi_vec), 32'd1);
    do_grant("second", 4'b0010);

    // Round robin.
    do_reset();
    usr_irq_req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_req("rr req");
      check_eq("rr vec", 32'(msi_vec), 32'(n));
      do_grant("rr", 4'(1 << n));
    end
    usr_irq_req = 4'd0;
    tick(3);
    usr_irq_req = 4'b1001;
    wait_req("rr2 req a");
    check_eq("rr2 vec a", 32'(msi_vec), 32'd0);
    do_grant("rr2 a", 4'b0001);
    wait_req("rr2 req b");
    check_eq("rr2 vec b", 32'(msi_vec), 32'd3);
    do_grant("rr2 b", 4'b1000);

    // Fail and retry.
    do_reset();
    usr_irq_req = 4'b0100;
    wait_req("retry req");
    check_eq("retry vec", 32'(msi_vec), 32'd2);
    msi_fail = 1'b1;
    tick(1);
    msi_fail = 1'b0;
    check_eq("retry low f", 32'(msi_req), 32'd0);
    for (int i = 1; i <= RETRY_GAP; i++) begin
      tick(1);
      check_eq("retry backoff low", 32'(msi_req), 32'd0);
    end
    tick(1);
    check_eq("retry reissue", 32'(msi_req), 32'd1);
    check_eq("retry same vec", 32'(msi_vec), 32'd2);
    do_grant("retry", 4'b0100);
`ifdef USR_IRQ_STATS_EN
    check_eq("stats sent", irq_sent_cnt, 32'd1);
    check_eq("stats fail", irq_fail_cnt, 32'd1);
`endif

    // Withdraw while pending (held off by irq_en so it stays unselected).
    do_reset();
    irq_en = 1'b0;
    usr_irq_req = 4'b0100;
    tick(2);
    check_eq("wd pending", 32'(irq_pending), 32'h4);
    usr_irq_req = 4'd0;
    tick(2);
    check_eq("wd cleared", 32'(irq_pending), 32'd0);
    base_r = req_rises;
    base_a = ack_pulses;
    irq_en = 1'b1;
    tick(10);
    check_eq("wd no req", 32'(req_rises), 32'(base_r));
    check_eq("wd no ack", 32'(ack_pulses), 32'(base_a));

    // Withdraw during backoff.
    usr_irq_req = 4'b0100;
    wait_req("wdb req");
    check_eq("wdb vec", 32'(msi_vec), 32'd2);
    msi_fail = 1'b1;
    tick(1);
    msi_fail = 1'b0;
    usr_irq_req = 4'd0;
    base_r = req_rises;
    base_a = ack_pulses;
    tick(3);
    check_eq("wdb pending", 32'(irq_pending), 32'd0);
    tick(25);
    check_eq("wdb no reissue", 32'(req_rises), 32'(base_r));
    check_eq("wdb no ack", 32'(ack_pulses), 32'(base_a));

    // Mask and enable.
    do_reset();
    irq_mask = 4'b0001;
    usr_irq_req = 4'b0011;
    wait_req("mask req");
    check_eq("mask vec", 32'(msi_vec), 32'd1);
    do_grant("mask", 4'b0010);
    tick(4);
    check_eq("masked idle", 32'(msi_req), 32'd0);
    check_eq("masked pending", 32'(irq_pending), 32'h1);
    irq_mask = 4'd0;
    wait_req("unmask req");
    check_eq("unmask vec", 32'(msi_vec), 32'd0);
    do_grant("unmask", 4'b0001);
    usr_irq_req = 4'd0;
    tick(3);
    irq_en = 1'b0;
    usr_irq_req = 4'b1000;
    base_r = req_rises;
    tick(6);
    check_eq("dis pending", 32'(irq_pending), 32'h8);
    check_eq("dis no req", 32'(req_rises), 32'(base_r));
    irq_en = 1'b1;
    wait_req("en req");
    check_eq("en vec", 32'(msi_vec), 32'd3);
    do_grant("en", 4'b1000);

    // Reset during ISSUE, late grant ignored.
    do_reset();
    usr_irq_req = 4'b0010;
    wait_req("rst req");
    rst_n = 1'b0;
    #1;
    check_eq("rst msi_req", 32'(msi_req), 32'd0);
    check_eq("rst msi_vec", 32'(msi_vec), 32'd0);
    check_eq("rst pending", 32'(irq_pending), 32'd0);
    check_eq("rst ack", 32'(usr_irq_ack), 32'd0);
    usr_irq_req = 4'd0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    msi_grant = 1'b1;
    tick(1);
    msi_grant = 1'b0;
    check_eq("late grant ack", 32'(usr_irq_ack), 32'd0);
    check_eq("late grant req", 32'(msi_req), 32'd0);
    tick(1);
    check_eq("late grant ack2", 32'(usr_irq_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usr_irq_responder.md
# usr_irq_responder

Shell-side responder for the user-interrupt handshake that a reconfigurable partition drives on `usr_irq_req` and expects answered on `usr_irq_ack`. It captures level requests, masks and round-robin arbitrates them, and forwards one vector at a time to the PCIe MSI request port. It retries vectors that fail, and acknowledges the partition only after the host side has granted the message. It sits in the static region in the `s_axi_aclk` domain, between the partition boundary and the PCIe interrupt interface.

## Interface
- `NUM_IRQ`, 4: number of user interrupt lines, legal range 1..16.
- `RETRY_GAP`, 16: idle cycles after `msi_fail` before reissue; 0 means reissue on the next cycle; legal range 0..255.
- `s_axi_aclk  in  1`: sole clock.
- `s_axi_aresetn  in  1`: asynchronous, active-low reset.
- `usr_irq_req  in  NUM_IRQ`: level requests from the partition, synchronous to `s_axi_aclk`.
- `usr_irq_ack  out  NUM_IRQ`: one-cycle acknowledge per line, one-hot or zero.
- `irq_mask  in  NUM_IRQ`: 1 = line excluded from arbitration.
- `irq_en  in  1`: global enable for new arbitration.
- `irq_pending  out  NUM_IRQ`: armed-and-unserved lines.
- `msi_req  out  1`: MSI request, held until `msi_grant` or `msi_fail`.
- `msi_vec  out  5`: index of the line being issued; stable while `msi_req`=1.
- `msi_grant  in  1`: one-cycle grant pulse.
- `msi_fail  in  1`: one-cycle failure pulse.
- `irq_sent_cnt  out  32`: present only with `USR_IRQ_STATS_EN`.
- `irq_fail_cnt  out  32`: present only with `USR_IRQ_STATS_EN`.

## Operation
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - `rr_ptr`=0;
  - every line in the ARMABLE state.
- Per-line states:
  - ARMABLE → PENDING when the registered `usr_irq_req[i]` is 1.
  - PENDING → ARMABLE if the request drops before the line is selected; this is a withdrawal and produces no ack.
  - After ack the line enters WAIT_LOW and returns to ARMABLE only once the registered request is seen at 0. A held-high request therefore never produces a second interrupt.
- `irq_pending[i]` = line in PENDING. Masked lines stay pending but are never selected.
- Global FSM:
  - IDLE: if `irq_en`=1 and (`irq_pending` & ~`irq_mask`)≠0, select the first eligible index at or above `rr_ptr`, wrapping modulo `NUM_IRQ`. Latch it into `msi_vec` and go to ISSUE.
  - ISSUE: `msi_req`=1.
    - On `msi_grant`: pulse `usr_irq_ack[vec]`, move the line to WAIT_LOW, set `rr_ptr`=(vec+1) mod `NUM_IRQ`, and go to IDLE.
    - On `msi_fail`: go to BACKOFF.
    - Grant and fail in the same cycle: grant wins.
  - BACKOFF: `msi_req`=0 and count `RETRY_GAP` cycles, then go to ISSUE with the same vector; there is no re-arbitration.
    - If the line's request drops during BACKOFF, abort to IDLE, clear the line to ARMABLE, and send no ack.
- Changes to `irq_mask` or `irq_en` during ISSUE or BACKOFF do not abort the in-flight vector; they affect only the next IDLE selection.
- Asserting reset mid-handshake clears everything immediately. A grant arriving later is ignored.

## Timing
- Request high at edge k → `irq_pending` high after edge k+1 → `msi_req` high after edge k+2 (FSM idle, line eligible).
- `msi_grant` sampled at edge g → after edge g: `msi_req`=0 and `usr_irq_ack` high for exactly one cycle; FSM in IDLE. The earliest next `msi_req` is after edge g+2.
- `msi_fail` sampled at edge f → `msi_req` is 0 from edge f until edge f+`RETRY_GAP`+1, then reasserts.
- `msi_vec` changes only on the IDLE→ISSUE transition.
- Back-to-back requests are serviced one per grant. There is no overlap between vectors.

## Configuration
- `USR_IRQ_STATS_EN` defined:
  - `irq_sent_cnt` increments on every grant.
  - `irq_fail_cnt` increments on every fail.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- `USR_IRQ_STATS_EN` not defined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Single request: `usr_irq_req`=4'b0010, grant 3 cycles after `msi_req` → `msi_vec`=1, one ack pulse on bit 1. Holding the request high gives no second `msi_req`; drop it, raise it again → a second interrupt is issued.
- Round-robin: `usr_irq_req`=4'b1111, immediate grants → `msi_vec` sequence 0,1,2,3. Then re-raise bits 0 and 3 with `rr_ptr`=0 → order 0,3.
- Fail and retry, `RETRY_GAP`=16: first attempt fails → `msi_req` low for 16 cycles, reissued with the same vector; the grant then acks. With stats enabled, `irq_fail_cnt`=1 and `irq_sent_cnt`=1.
- Withdraw: request bit 2 drops while pending → no `msi_req` for vector 2, no ack. Request bit 2 drops during BACKOFF → FSM returns to IDLE, no ack.
- Mask and enable: `irq_mask`=4'b0001 with requests on bits 0 and 1 → only vector 1 is issued. Unmask → vector 0 is issued. `irq_en`=0 → no new `msi_req`, `irq_pending` still tracks requests.
- Reset mid-ISSUE: deassert `s_axi_aresetn` while `msi_req`=1 → all outputs 0 immediately. A `msi_grant` after reset release produces no ack.
